// File: rtl/sec32_pkg.sv
// Shared widths, code-column mapping and codeword layout for the 32-bit SEC encoder.
package sec32_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 8;
  localparam int COL_W  = CHK_W - ROWS;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  check;
  } codeword_t;

  // Column code is c+1 so no data bit gets a zero column code.
  function automatic logic [COL_W-1:0] col_code(input int c);
    return COL_W'(c + 1);
  endfunction

endpackage

// File: rtl/sec32_ckgen.sv
// Combinational SEC parity generator: row parities and column parities on separate inputs.
// Zero latency, no flow control; the two halves feed different pipeline stages.
module sec32_ckgen
  import sec32_pkg::*;
(
  input  logic [DATA_W-1:0] row_data,
  input  logic [DATA_W-1:0] col_data,
  output logic [ROWS-1:0]   row_par,
  output logic [COL_W-1:0]  col_par
);

  always_comb begin
    row_par = '0;
    for (int r = 0; r < ROWS; r++) row_par[r] = ^row_data[COLS*r +: COLS];
  end

  always_comb begin
    col_par = '0;
    for (int i = 0; i < DATA_W; i++)
      col_par = col_par ^ (col_data[i] ? col_code(i % COLS) : '0);
  end

endmodule

// File: rtl/sec32_encoder.sv
// 32-bit SEC encoder emitting {data, check}; optional key lock under SEC32_KEY_LOCK_EN.
// Latency 2 cycles at 1 word/cycle; a stalled S2 holds its codeword and backs up through S1 to in_ready.
module sec32_encoder
  import sec32_pkg::*;
#(
`ifdef SEC32_KEY_LOCK_EN
  parameter int               KEY_W    = 29,
  parameter logic [KEY_W-1:0] LOCK_KEY = 29'h1D26_6F9C,
`endif
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  word_cnt
`ifdef SEC32_KEY_LOCK_EN
  ,
  input  logic              key_shift,
  input  logic              key_sin,
  output logic              key_ok
`endif
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [ROWS-1:0]   s1_row;
  logic [ROWS-1:0]   row_par;
  logic [COL_W-1:0]  col_par;
  logic [CHK_W-1:0]  mask;
  logic              s1_adv;
  logic              s2_adv;
  codeword_t         s2_q;

  assign s2_adv    = !out_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_data  = s2_q.data;
  assign out_check = s2_q.check;

  sec32_ckgen u_ckgen (
    .row_data (in_data),
    .col_data (s1_data),
    .row_par  (row_par),
    .col_par  (col_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_row   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_row  <= row_par;
      end
    end
  end

  // An empty S1 with S2 free drops out_valid; a held S2 word is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s2_q      <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        s2_q.data  <= s1_data;
        s2_q.check <= {col_par, s1_row} ^ mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_cnt <= '0;
    else if (cnt_clr)
      word_cnt <= '0;
    else if (out_valid && out_ready && (word_cnt != {CNT_W{1'b1}}))
      word_cnt <= word_cnt + 1'b1;
  end

`ifdef SEC32_KEY_LOCK_EN
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] key_diff;

  assign key_diff = key ^ LOCK_KEY;

  // Each wrong key bit folds onto one check bit, so any single wrong bit is visible.
  always_comb begin
    mask = '0;
    for (int i = 0; i < KEY_W; i++) mask[i % CHK_W] = mask[i % CHK_W] ^ key_diff[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key    <= '0;
      key_ok <= 1'b0;
    end else begin
      if (key_shift) key <= {key[KEY_W-2:0], key_sin};
      key_ok <= (key_diff == '0);
    end
  end
`else
  assign mask = '0;
`endif

endmodule

// File: tb/tb_sec32_encoder.sv
// Directed and random checks of sec32_encoder against a codeword scoreboard and a bench-side corrector.
module tb_sec32_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        cnt_clr;
  logic [7:0]  word_cnt;
`ifdef SEC32_KEY_LOCK_EN
  logic        key_shift;
  logic        key_sin;
  logic        key_ok;
  localparam logic [28:0] LK = 29'h1D26_6F9C;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [39:0] sb[$];
  logic [39:0] exp_cw;
  logic [39:0] held;
  logic [39:0] cw;
  logic [7:0]  exp_mask = 8'h00;
  bit          stalled = 1'b0;
  bit          acc = 1'b0;
  bit          rnd = 1'b0;

  always #5 clk = ~clk;

  sec32_encoder #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_check (out_check),
    .cnt_clr   (cnt_clr),
    .word_cnt  (word_cnt)
`ifdef SEC32_KEY_LOCK_EN
    ,
    .key_shift (key_shift),
    .key_sin   (key_sin),
    .key_ok    (key_ok)
`endif
  );

  // Reference code: row r = bits 8r..8r+7; column m = all columns whose (c+1) has bit m set.
  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0]  c;
    logic [31:0] sel;
    c = 8'h00;
    for (int r = 0; r < 4; r++) c[r] = ^d[8*r +: 8];
    for (int m = 0; m < 4; m++) begin
      sel = 32'h0;
      for (int k = 0; k < 8; k++)
        if ((((k + 1) >> m) & 1) == 1) sel = sel | (32'h0101_0101 << k);
      c[4+m] = ^(d & sel);
    end
    return c;
  endfunction

  function automatic logic [31:0] correct(input logic [31:0] d, input logic [7:0] c);
    logic [7:0] syn;
    syn = c ^ ref_check(d);
    for (int i = 0; i < 32; i++)
      if (syn == {4'((i % 8) + 1), 4'(1 << (i / 8))}) d[i] = ~d[i];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    acc = 1'b0;
    if (rst_n) begin
      if (stalled) chk("hold", {23'd0, out_valid, out_data, out_check}, {23'd0, 1'b1, held});
      if (in_valid && in_ready) begin
        sb.push_back({in_data, ref_check(in_data) ^ exp_mask});
        acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_cw = sb.pop_front();
          chk("codeword", 64'({out_data, out_check}), 64'(exp_cw));
          if (exp_mask == 8'h00) begin
            cw = {out_data, out_check} ^ (40'd1 << $urandom_range(0, 39));
            chk("corrector", 64'(correct(cw[39:8], cw[7:0])), 64'(exp_cw[39:8]));
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_data, out_check};
    end
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc) break;
    end
    chk("send_acc", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk("drain", 64'(sb.size()), 64'(0));
    tick();
  endtask

`ifdef SEC32_KEY_LOCK_EN
  task automatic shift_key(input logic [28:0] k);
    key_shift = 1'b1;
    for (int i = 28; i >= 0; i--) begin
      key_sin = k[i];
      tick();
    end
    key_shift = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
`ifdef SEC32_KEY_LOCK_EN
    key_shift = 1'b0; key_sin = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_check", 64'(out_check), 64'(0));
    chk("rst_word_cnt",  64'(word_cnt),  64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    // Single words: latency and known check values.
    out_ready = 1'b1;
    send(32'h0000_0001);
    chk("lat1_idle", 64'(out_valid), 64'(0));
    tick();
    chk("lat2_valid", 64'(out_valid), 64'(1));
    chk("chk_0001",   64'(out_check), 64'(8'h11));
    tick();
    chk("cnt_one", 64'(word_cnt), 64'(1));
    send(32'hFFFF_FFFF);
    tick();
    chk("chk_ffff", 64'(out_check), 64'(ref_check(32'hFFFF_FFFF)));
    send(32'h8000_0000);
    tick();
    chk("chk_8000", 64'(out_check), 64'(8'h88));
    drain();

    // Random words with random downstream stalls and input bubbles.
    rnd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send($urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd = 1'b0;
    drain();

    // Full stall: S1 and S2 fill, then drain at full rate.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001; tick();
    in_data   = 32'hA5A5_0002; tick();
    in_data   = 32'hA5A5_0003; tick(); tick();
    chk("stall_in_ready", 64'(in_ready),  64'(0));
    chk("stall_accepted", 64'(sb.size()), 64'(2));
    chk("stall_head",     64'(out_data),  64'(32'hA5A5_0001));
    out_ready = 1'b1;
    tick();
    chk("resume_acc", 64'(acc), 64'(1));
    for (int k = 4; k < 8; k++) begin
      in_data = 32'hA5A5_0000 + 32'(k);
      tick();
      chk("stream_acc",   64'(acc),       64'(1));
      chk("stream_valid", 64'(out_valid), 64'(1));
    end
    drain();

    // Counter clear, then saturation of the 8-bit counter.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("cnt_clear", 64'(word_cnt), 64'(0));
    in_valid = 1'b1;
    for (int k = 0; k < 255; k++) begin
      in_data = 32'h0100_0000 ^ 32'(k * 7);
      tick();
    end
    drain();
    chk("cnt_full", 64'(word_cnt), 64'(8'hFF));
    send(32'h1234_5678);
    drain();
    chk("cnt_sat", 64'(word_cnt), 64'(8'hFF));

    // Clear wins over a simultaneous transfer.
    send(32'hCAFE_F00D);
    tick();
    chk("clr_pre_valid", 64'(out_valid), 64'(1));
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_vs_inc", 64'(word_cnt), 64'(0));

    // Reset with a stalled word in S2.
    out_ready = 1'b0;
    send(32'hDEAD_BEEF);
    tick();
    chk("prerst_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'(0));
    sb.delete();
    stalled = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_in_ready", 64'(in_ready),  64'(1));
    chk("rst2_data",     64'(out_data),  64'(0));
    tick();
    chk("rst2_no_word",  64'(out_valid), 64'(0));
    out_ready = 1'b1;
    send(32'h0F0F_1234);
    drain();

`ifdef SEC32_KEY_LOCK_EN
    chk("key_locked", 64'(key_ok), 64'(0));
    shift_key(LK);
    chk("key_ok", 64'(key_ok), 64'(1));
    send(32'h1357_9BDF);
    drain();
    shift_key(LK ^ 29'h1);
    chk("key_bad", 64'(key_ok), 64'(0));
    exp_mask = 8'h01;
    send(32'h1357_9BDF);
    drain();
    exp_mask = 8'h00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
